pipe_stage_skid: RTL and testbench

- Parametrised pipeline stage register and generalised successor to the fixed IF/ID register.
- Carries an arbitrary-width payload, for example {PC, instr}, between two pipeline stages using a valid/ready handshake.
- Optional 2-entry skid buffer, so in_ready is a registered signal and throughput is one transfer per cycle under backpressure.
- Synchronous flush squashes the stage on branch or exception.
- Used for IF/ID, ID/EX and later stage boundaries.

---
 rtl/pipe_pkg.sv | 51 +++++
 rtl/pipe_slot.sv | 53 +++++
 rtl/pipe_stage_skid.sv | 139 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline package: inter-stage bundle types, NOP encoding
// and a small occupancy helper used by the stage registers.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  localparam int IF_ID_W = $bits(if_id_t);

  localparam if_id_t IF_ID_RESET = '{
    pc:    32'h0,
    instr: NOP_INSTR
  };

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } id_ex_t;

  localparam int ID_EX_W = $bits(id_ex_t);

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } ex_mem_t;

  localparam int EX_MEM_W = $bits(ex_mem_t);

  function automatic logic [1:0] occ_count(
    input logic a,
    input logic b
  );
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid+data holding register with load, drop and clear.
// Ports: clock/reset, clear (squash to RESET_VAL), load (take
// load_data, mark valid), drop (mark empty, data kept),
// valid/data outputs straight from the flops.
module pipe_slot #(
  parameter int               DATA_W    = 64,
  parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              drop,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic              valid_q;
  logic              valid_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  // Load wins over drop so a slot can be emptied and
  // refilled in the same cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      data_d  = RESET_VAL;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (drop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with optional 2-entry skid.
// Ports: clock, reset (sync, high), flush; in_valid/in_ready/
// in_data upstream; out_valid/out_ready/out_data downstream;
// occupancy = held entries (0..2, or 0..1 without skid).
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int               DATA_W    = 64,
  parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}},
  parameter int               SKID      = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              accept;
  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic              main_load;
  logic              main_drop;
  logic [DATA_W-1:0] main_src;
  logic              skid_valid;

  assign accept = in_valid & in_ready;

  pipe_slot #(
    .DATA_W    (DATA_W),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush),
    .load      (main_load),
    .drop      (main_drop),
    .load_data (main_src),
    .valid     (main_valid),
    .data      (main_data)
  );

  generate
    if (SKID != 0) begin : g_skid

      logic              skid_load;
      logic              skid_drop;
      logic [DATA_W-1:0] skid_data;
      logic              skid_valid_d;
      logic              in_ready_q;
      logic              in_ready_d;

      // Main refills whenever it is empty or draining;
      // the skid entry is older than in_data, so it goes first.
      always_comb begin
        main_load = 1'b0;
        main_drop = 1'b0;
        main_src  = in_data;
        skid_load = 1'b0;
        skid_drop = 1'b0;
        if (!main_valid || out_ready) begin
          if (skid_valid) begin
            main_load = 1'b1;
            main_src  = skid_data;
            skid_drop = 1'b1;
            skid_load = accept;
          end else if (accept) begin
            main_load = 1'b1;
          end else begin
            main_drop = 1'b1;
          end
        end else if (accept) begin
          skid_load = 1'b1;
        end
      end

      assign skid_valid_d = skid_load |
                            (skid_valid & ~skid_drop);

      always_comb begin
        in_ready_d = ~skid_valid_d;
        if (flush) begin
          in_ready_d = 1'b1;
        end
      end

      // The flop comes out of reset already set so the
      // stage is ready on the first cycle after release;
      // the reset gate keeps it low while reset is held.
      always_ff @(posedge clock) begin
        if (reset) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= in_ready_d;
        end
      end

      assign in_ready = in_ready_q & ~reset;

      pipe_slot #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
      ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush),
        .load      (skid_load),
        .drop      (skid_drop),
        .load_data (in_data),
        .valid     (skid_valid),
        .data      (skid_data)
      );

    end else begin : g_noskid

      always_comb begin
        main_load = accept;
        main_drop = main_valid & out_ready;
        main_src  = in_data;
      end

      assign skid_valid = 1'b0;

      assign in_ready = (out_ready | ~main_valid) &
                        ~reset;

    end
  endgenerate

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = occ_count(main_valid, skid_valid);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: one SKID=1 and one SKID=0
// instance on a shared clock, reset and flush.
module tb_pipe_stage_skid;

  localparam logic [7:0] RV = 8'hEE;

  logic       clock = 1'b0;
  logic       reset;
  logic       flush;

  logic       s_in_valid;
  logic       s_in_ready;
  logic [7:0] s_in_data;
  logic       s_out_valid;
  logic       s_out_ready;
  logic [7:0] s_out_data;
  logic [1:0] s_occ;

  logic       n_in_valid;
  logic       n_in_ready;
  logic [7:0] n_in_data;
  logic       n_out_valid;
  logic       n_out_ready;
  logic [7:0] n_out_data;
  logic [1:0] n_occ;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipe_stage_skid #(
    .DATA_W    (8),
    .RESET_VAL (RV),
    .SKID      (1)
  ) dut_s (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .occupancy (s_occ)
  );

  pipe_stage_skid #(
    .DATA_W    (8),
    .RESET_VAL (RV),
    .SKID      (0)
  ) dut_n (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (n_in_valid),
    .in_ready  (n_in_ready),
    .in_data   (n_in_data),
    .out_valid (n_out_valid),
    .out_ready (n_out_ready),
    .out_data  (n_out_data),
    .occupancy (n_occ)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      assert (s_occ <= 2'd2) else begin
        errors++;
        $error("FAIL s_occ_bound observed=%0d expected<=2",
               s_occ);
      end
      assert (n_occ <= 2'd1) else begin
        errors++;
        $error("FAIL n_occ_bound observed=%0d expected<=1",
               n_occ);
      end
    end
  end

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    s_in_valid  = 1'b0;
    s_in_data   = 8'h00;
    s_out_ready = 1'b0;
    n_in_valid  = 1'b0;
    n_in_data   = 8'h00;
    n_out_ready = 1'b0;

    // reset and idle
    tick();
    tick();
    chk("s_rdy_in_reset", s_in_ready, 0);
    chk("n_rdy_in_reset", n_in_ready, 0);
    reset = 1'b0;
    #1;
    chk("s_rst_valid", s_out_valid, 0);
    chk("s_rst_data", s_out_data, RV);
    chk("s_rst_occ", s_occ, 0);
    chk("s_rst_rdy", s_in_ready, 1);
    chk("n_rst_valid", n_out_valid, 0);
    chk("n_rst_data", n_out_data, RV);
    chk("n_rst_rdy", n_in_ready, 1);
    tick();
    chk("s_idle_valid", s_out_valid, 0);
    chk("s_idle_rdy", s_in_ready, 1);

    // streaming on both instances
    s_out_ready = 1'b1;
    n_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_in_valid = 1'b1;
      s_in_data  = 8'(i);
      n_in_valid = 1'b1;
      n_in_data  = 8'(i);
      #1;
      chk("s_stream_rdy", s_in_ready, 1);
      chk("n_stream_rdy", n_in_ready, 1);
      tick();
      chk("s_stream_valid", s_out_valid, 1);
      chk("s_stream_data", s_out_data, i);
      chk("s_stream_occ", s_occ, 1);
      chk("n_stream_data", n_out_data, i);
    end
    s_in_valid = 1'b0;
    n_in_valid = 1'b0;
    tick();
    chk("s_stream_drain", s_out_valid, 0);
    chk("s_stream_occ0", s_occ, 0);
    chk("n_stream_drain", n_out_valid, 0);
    chk("s_drain_data", s_out_data, 8'h08);

    // backpressure fills main then skid
    s_out_ready = 1'b0;
    s_in_valid  = 1'b1;
    s_in_data   = 8'h11;
    tick();
    chk("s_bp_a_occ", s_occ, 1);
    chk("s_bp_a_rdy", s_in_ready, 1);
    s_in_data = 8'h22;
    tick();
    chk("s_bp_b_occ", s_occ, 2);
    chk("s_bp_b_rdy", s_in_ready, 0);
    chk("s_bp_b_data", s_out_data, 8'h11);
    s_in_data = 8'h33;
    tick();
    chk("s_bp_c_occ", s_occ, 2);
    chk("s_bp_c_rdy", s_in_ready, 0);
    chk("s_bp_hold_data", s_out_data, 8'h11);
    chk("s_bp_hold_valid", s_out_valid, 1);
    s_out_ready = 1'b1;
    tick();
    chk("s_bp_out2", s_out_data, 8'h22);
    chk("s_bp_out2_valid", s_out_valid, 1);
    chk("s_bp_out2_occ", s_occ, 1);
    chk("s_bp_out2_rdy", s_in_ready, 1);
    tick();
    chk("s_bp_out3", s_out_data, 8'h33);
    chk("s_bp_out3_valid", s_out_valid, 1);
    chk("s_bp_out3_occ", s_occ, 1);
    s_in_valid = 1'b0;
    tick();
    chk("s_bp_empty", s_out_valid, 0);
    chk("s_bp_empty_occ", s_occ, 0);

    // flush while full
    s_out_ready = 1'b0;
    s_in_valid  = 1'b1;
    s_in_data   = 8'hAA;
    tick();
    s_in_data = 8'hBB;
    tick();
    chk("s_fl_full_occ", s_occ, 2);
    flush     = 1'b1;
    s_in_data = 8'h44;
    tick();
    flush      = 1'b0;
    s_in_valid = 1'b0;
    chk("s_fl_valid", s_out_valid, 0);
    chk("s_fl_data", s_out_data, RV);
    chk("s_fl_occ", s_occ, 0);
    chk("s_fl_rdy", s_in_ready, 1);
    s_out_ready = 1'b1;
    tick();
    chk("s_fl_no44", s_out_valid, 0);
    chk("s_fl_no44_data", s_out_data, RV);

    // flush discards a payload accepted in the same cycle
    s_out_ready = 1'b0;
    s_in_valid  = 1'b1;
    s_in_data   = 8'h12;
    tick();
    chk("s_fla_occ1", s_occ, 1);
    flush     = 1'b1;
    s_in_data = 8'h44;
    #1;
    chk("s_fla_rdy", s_in_ready, 1);
    tick();
    flush      = 1'b0;
    s_in_valid = 1'b0;
    chk("s_fla_valid", s_out_valid, 0);
    chk("s_fla_occ", s_occ, 0);
    chk("s_fla_data", s_out_data, RV);

    // reset mid-stall
    s_in_valid = 1'b1;
    s_in_data  = 8'h55;
    tick();
    s_in_valid = 1'b0;
    chk("s_rs_data", s_out_data, 8'h55);
    chk("s_rs_occ", s_occ, 1);
    reset = 1'b1;
    #1;
    chk("s_rs_rdy_low", s_in_ready, 0);
    tick();
    chk("s_rs_valid", s_out_valid, 0);
    chk("s_rs_rvdata", s_out_data, RV);
    chk("s_rs_occ0", s_occ, 0);
    reset = 1'b0;
    #1;
    chk("s_rs_rdy", s_in_ready, 1);
    s_out_ready = 1'b1;
    tick();
    chk("s_rs_no55", s_out_valid, 0);

    // SKID=0 stall and combinational release
    n_out_ready = 1'b0;
    n_in_valid  = 1'b1;
    n_in_data   = 8'h66;
    #1;
    chk("n_st_rdy_empty", n_in_ready, 1);
    tick();
    n_in_data = 8'h77;
    #1;
    chk("n_st_valid", n_out_valid, 1);
    chk("n_st_data", n_out_data, 8'h66);
    chk("n_st_rdy", n_in_ready, 0);
    tick();
    chk("n_st_hold", n_out_data, 8'h66);
    chk("n_st_hold_occ", n_occ, 1);
    n_out_ready = 1'b1;
    #1;
    chk("n_rel_rdy", n_in_ready, 1);
    tick();
    chk("n_rel_data", n_out_data, 8'h77);
    chk("n_rel_valid", n_out_valid, 1);
    n_in_valid = 1'b0;
    tick();
    chk("n_rel_empty", n_out_valid, 0);
    chk("n_rel_occ", n_occ, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
